// File: rtl/cache_bus_arbiter.sv
// Two-requester (icache/dcache) arbiter onto a single downstream bus.
// Round-robin grant in IDLE, then one transaction owns the bus until it returns to IDLE.
module cache_bus_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_valid_i,
  output logic [1:0]                 req_ready_o,
  input  logic [1:0][31:0]           req_addr_i,
  input  logic [1:0]                 req_write_i,
  input  logic [1:0][LEN_WIDTH-1:0]  req_len_i,
  input  logic [1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [1:0]                 wvalid_i,
  input  logic [1:0]                 wlast_i,
  output logic [1:0]                 wready_o,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic [1:0]                 rvalid_o,
  output logic                       rlast_o,
  input  logic [1:0]                 rready_i,
  output logic [1:0]                 wdone_o,
  output logic                       bus_req_valid_o,
  input  logic                       bus_req_ready_i,
  output logic [31:0]                bus_addr_o,
  output logic                       bus_write_o,
  output logic [LEN_WIDTH-1:0]       bus_len_o,
  output logic [DATA_WIDTH-1:0]      bus_wdata_o,
  output logic                       bus_wvalid_o,
  output logic                       bus_wlast_o,
  input  logic                       bus_wready_i,
  input  logic [DATA_WIDTH-1:0]      bus_rdata_i,
  input  logic                       bus_rvalid_i,
  input  logic                       bus_rlast_i,
  output logic                       bus_rready_o,
  input  logic                       bus_bvalid_i
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_WRESP = 3'd3,
    ST_RDATA = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_grant;
  logic        r_last_grant;
  logic [1:0]  r_wdone;
  logic [1:0]  w_wdone_next;
  logic        w_pick;
  logic [1:0]  w_grant_oh;

  // Contention goes to whoever was not served last; a lone requester always wins.
  function automatic logic rr_pick(input logic [1:0] valid, input logic last);
    logic pick;
    if (valid == 2'b11) begin
      pick = ~last;
    end else if (valid[1]) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

  assign w_pick     = rr_pick(req_valid_i, r_last_grant);
  assign w_grant_oh = r_grant ? 2'b10 : 2'b01;
  assign wdone_o    = r_wdone;

  // State, grant and completion-pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_wdone      <= 2'b00;
    end else begin
      r_state <= w_next_state;
      r_wdone <= w_wdone_next;
      if ((r_state == ST_IDLE) && (req_valid_i != 2'b00)) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
      end
    end
  end

  // Next state and channel steering; only the owning channel state drives its valids.
  always_comb begin
    w_next_state    = r_state;
    w_wdone_next    = 2'b00;
    req_ready_o     = 2'b00;
    wready_o        = 2'b00;
    rdata_o         = '0;
    rvalid_o        = 2'b00;
    rlast_o         = 1'b0;
    bus_req_valid_o = 1'b0;
    bus_addr_o      = 32'h0000_0000;
    bus_write_o     = 1'b0;
    bus_len_o       = '0;
    bus_wdata_o     = '0;
    bus_wvalid_o    = 1'b0;
    bus_wlast_o     = 1'b0;
    bus_rready_o    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid_i != 2'b00) begin
          w_next_state = ST_ADDR;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ADDR: begin
        bus_req_valid_o = 1'b1;
        bus_addr_o      = req_addr_i[r_grant];
        bus_write_o     = req_write_i[r_grant];
        bus_len_o       = req_len_i[r_grant];
        req_ready_o     = bus_req_ready_i ? w_grant_oh : 2'b00;
        if (bus_req_ready_i) begin
          w_next_state = req_write_i[r_grant] ? ST_WDATA : ST_RDATA;
        end else begin
          w_next_state = ST_ADDR;
        end
      end
      ST_WDATA: begin
        bus_wdata_o  = wdata_i[r_grant];
        bus_wvalid_o = wvalid_i[r_grant];
        bus_wlast_o  = wlast_i[r_grant];
        wready_o     = bus_wready_i ? w_grant_oh : 2'b00;
        if (wvalid_i[r_grant] && bus_wready_i && wlast_i[r_grant]) begin
          w_next_state = ST_WRESP;
        end else begin
          w_next_state = ST_WDATA;
        end
      end
      ST_WRESP: begin
        if (bus_bvalid_i) begin
          w_wdone_next = w_grant_oh;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WRESP;
        end
      end
      ST_RDATA: begin
        rdata_o      = bus_rdata_i;
        rvalid_o     = bus_rvalid_i ? w_grant_oh : 2'b00;
        rlast_o      = bus_rlast_i;
        bus_rready_o = rready_i[r_grant];
        if (bus_rvalid_i && rready_i[r_grant] && bus_rlast_i) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RDATA;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Bench for cache_bus_arbiter: cycle-level requester + bus model with
// queue scoreboards for granted requests, read beats and write beats.
module tb_cache_bus_arbiter;
  localparam int DW = 32;
  localparam int LW = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          req_valid_i;
  logic [1:0]          req_ready_o;
  logic [1:0][31:0]    req_addr_i;
  logic [1:0]          req_write_i;
  logic [1:0][LW-1:0]  req_len_i;
  logic [1:0][DW-1:0]  wdata_i;
  logic [1:0]          wvalid_i;
  logic [1:0]          wlast_i;
  logic [1:0]          wready_o;
  logic [DW-1:0]       rdata_o;
  logic [1:0]          rvalid_o;
  logic                rlast_o;
  logic [1:0]          rready_i;
  logic [1:0]          wdone_o;
  logic                bus_req_valid_o;
  logic                bus_req_ready_i;
  logic [31:0]         bus_addr_o;
  logic                bus_write_o;
  logic [LW-1:0]       bus_len_o;
  logic [DW-1:0]       bus_wdata_o;
  logic                bus_wvalid_o;
  logic                bus_wlast_o;
  logic                bus_wready_i;
  logic [DW-1:0]       bus_rdata_i;
  logic                bus_rvalid_i;
  logic                bus_rlast_i;
  logic                bus_rready_o;
  logic                bus_bvalid_i;

  always #5 clk = ~clk;

  cache_bus_arbiter #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_write_i(req_write_i), .req_len_i(req_len_i),
    .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wlast_i(wlast_i), .wready_o(wready_o),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rlast_o(rlast_o), .rready_i(rready_i),
    .wdone_o(wdone_o),
    .bus_req_valid_o(bus_req_valid_o), .bus_req_ready_i(bus_req_ready_i),
    .bus_addr_o(bus_addr_o), .bus_write_o(bus_write_o), .bus_len_o(bus_len_o),
    .bus_wdata_o(bus_wdata_o), .bus_wvalid_o(bus_wvalid_o), .bus_wlast_o(bus_wlast_o),
    .bus_wready_i(bus_wready_i),
    .bus_rdata_i(bus_rdata_i), .bus_rvalid_i(bus_rvalid_i), .bus_rlast_i(bus_rlast_i),
    .bus_rready_o(bus_rready_o), .bus_bvalid_i(bus_bvalid_i)
  );

  typedef struct packed { logic idx; logic [31:0] addr; logic write; logic [LW-1:0] len; } areq_t;
  typedef struct packed { logic idx; logic [DW-1:0] data; logic last; } beat_t;
  typedef enum logic [1:0] {PH_NONE, PH_R, PH_W, PH_B} phase_t;

  areq_t addr_q[$];
  beat_t rd_q[$];
  beat_t wr_q[$];
  int checks = 0;
  int failures = 0;

  phase_t        phase;
  logic          cur_idx;
  logic [31:0]   cur_addr;
  int            cur_len, beat;
  int            aready_hold, rready_hold, stall_cnt, wdone_cnt;
  logic [1:0]    w_pend, exp_wdone, s_req_hs, s_w_hs;
  int            wbeat[2], wlen[2];
  logic [DW-1:0] wbase[2];
  logic          s_bus_req_hs, s_r_hs, s_bw_last_hs, s_b;
  areq_t         s_areq;

  function automatic logic [1:0] oh(input logic i);
    return i ? 2'b10 : 2'b01;
  endfunction

  function automatic bit busy();
    return (addr_q.size() != 0) || (rd_q.size() != 0) || (wr_q.size() != 0) ||
           (phase != PH_NONE) || (req_valid_i != 2'b00) || (w_pend != 2'b00) ||
           (exp_wdone != 2'b00) || s_r_hs || s_b || s_bus_req_hs || s_bw_last_hs;
  endfunction

  task automatic model_clear();
    addr_q.delete(); rd_q.delete(); wr_q.delete();
    phase = PH_NONE; cur_idx = 1'b0; cur_addr = 32'h0; cur_len = 0; beat = 0;
    aready_hold = 0; rready_hold = 0; stall_cnt = 0; wdone_cnt = 0;
    w_pend = 2'b00; exp_wdone = 2'b00; s_req_hs = 2'b00; s_w_hs = 2'b00;
    s_bus_req_hs = 1'b0; s_r_hs = 1'b0; s_bw_last_hs = 1'b0; s_b = 1'b0;
    for (int k = 0; k < 2; k++) begin wbeat[k] = 0; wlen[k] = 0; wbase[k] = '0; end
    req_valid_i = 2'b00; req_addr_i = '0; req_write_i = 2'b00; req_len_i = '0;
    wdata_i = '0; wvalid_i = 2'b00; wlast_i = 2'b00; rready_i = 2'b11;
    bus_req_ready_i = 1'b0; bus_wready_i = 1'b0; bus_rdata_i = '0;
    bus_rvalid_i = 1'b0; bus_rlast_i = 1'b0; bus_bvalid_i = 1'b0;
  endtask

  task automatic issue(input int k, input logic [31:0] addr, input logic wr, input int len,
                       input logic [DW-1:0] wb);
    areq_t a;
    beat_t e;
    req_valid_i[k] = 1'b1; req_addr_i[k] = addr; req_write_i[k] = wr; req_len_i[k] = LW'(len);
    a.idx = k[0]; a.addr = addr; a.write = wr; a.len = LW'(len);
    addr_q.push_back(a);
    if (wr) begin
      w_pend[k] = 1'b1; wbeat[k] = 0; wlen[k] = len; wbase[k] = wb;
    end
    for (int b = 0; b <= len; b++) begin
      e.idx = k[0];
      e.data = wr ? (wb + DW'(b)) : (addr + 32'(b));
      e.last = (b == len);
      if (wr) wr_q.push_back(e); else rd_q.push_back(e);
    end
  endtask

  // Negedge: apply effects of last edge's handshakes, then drive the next cycle's inputs.
  task automatic cyc_begin();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (s_req_hs[k]) req_valid_i[k] = 1'b0;
      if (s_w_hs[k]) begin
        if (wbeat[k] == wlen[k]) w_pend[k] = 1'b0; else wbeat[k]++;
      end
    end
    if (s_bus_req_hs) begin
      phase = s_areq.write ? PH_W : PH_R; cur_idx = s_areq.idx;
      cur_addr = s_areq.addr; cur_len = int'(s_areq.len); beat = 0;
    end else if (s_r_hs) begin
      if (beat == cur_len) phase = PH_NONE; else beat++;
    end else if (s_bw_last_hs) begin
      phase = PH_B;
    end else if (s_b) begin
      phase = PH_NONE;
    end
    s_req_hs = 2'b00; s_w_hs = 2'b00; s_bus_req_hs = 1'b0; s_r_hs = 1'b0;
    s_bw_last_hs = 1'b0; s_b = 1'b0;
    if (bus_req_valid_o && aready_hold > 0) begin
      bus_req_ready_i = 1'b0; aready_hold--;
    end else begin
      bus_req_ready_i = 1'b1;
    end
    bus_rvalid_i = (phase == PH_R);
    bus_rdata_i  = cur_addr + 32'(beat);
    bus_rlast_i  = (phase == PH_R) && (beat == cur_len);
    if (phase == PH_R && rready_hold > 0) begin
      rready_i = cur_idx ? 2'b01 : 2'b10; rready_hold--;
    end else begin
      rready_i = 2'b11;
    end
    bus_wready_i = (phase == PH_W);
    bus_bvalid_i = (phase == PH_B);
    for (int k = 0; k < 2; k++) begin
      wvalid_i[k] = w_pend[k];
      wdata_i[k]  = wbase[k] + DW'(wbeat[k]);
      wlast_i[k]  = w_pend[k] && (wbeat[k] == wlen[k]);
    end
  endtask

  // Sample outputs just after the drive point and score them.
  task automatic cyc_end();
    beat_t e;
    logic [1:0] exp_rr;
    #1;
    checks++;
    if (wdone_o !== exp_wdone) begin
      failures++; $display("FAIL wdone got=%b exp=%b t=%0t", wdone_o, exp_wdone, $time);
    end
    if (wdone_o != 2'b00) wdone_cnt++;
    exp_wdone = bus_bvalid_i ? oh(cur_idx) : 2'b00;
    if (bus_req_valid_o === 1'b1) begin
      checks++;
      if (addr_q.size() == 0) begin
        failures++; $display("FAIL unexpected_bus_req addr=%h t=%0t", bus_addr_o, $time);
      end else begin
        if ({bus_addr_o, bus_write_o, bus_len_o} !== {addr_q[0].addr, addr_q[0].write, addr_q[0].len}) begin
          failures++;
          $display("FAIL bus_req got=%h/%b/%h exp=%h/%b/%h", bus_addr_o, bus_write_o, bus_len_o,
                   addr_q[0].addr, addr_q[0].write, addr_q[0].len);
        end
        exp_rr = bus_req_ready_i ? oh(addr_q[0].idx) : 2'b00;
        checks++;
        if (req_ready_o !== exp_rr) begin
          failures++; $display("FAIL req_ready got=%b exp=%b t=%0t", req_ready_o, exp_rr, $time);
        end
        if (!bus_req_ready_i) stall_cnt++;
        if (bus_req_ready_i) begin s_bus_req_hs = 1'b1; s_areq = addr_q.pop_front(); end
      end
    end else begin
      checks++;
      if (req_ready_o !== 2'b00) begin
        failures++; $display("FAIL req_ready_idle got=%b exp=00 t=%0t", req_ready_o, $time);
      end
    end
    for (int k = 0; k < 2; k++) s_req_hs[k] = req_ready_o[k] && req_valid_i[k];
    checks++;
    if (phase == PH_R) begin
      if (rvalid_o !== oh(cur_idx) || bus_rready_o !== rready_i[cur_idx] || rlast_o !== bus_rlast_i) begin
        failures++;
        $display("FAIL rd_ctrl got=%b/%b/%b exp=%b/%b/%b t=%0t", rvalid_o, bus_rready_o, rlast_o,
                 oh(cur_idx), rready_i[cur_idx], bus_rlast_i, $time);
      end
      if (bus_rvalid_i && rready_i[cur_idx]) begin
        checks++;
        if (rd_q.size() == 0) begin
          failures++; $display("FAIL rd_extra_beat data=%h", rdata_o);
        end else begin
          e = rd_q.pop_front();
          if (rdata_o !== e.data || cur_idx !== e.idx || rlast_o !== e.last) begin
            failures++;
            $display("FAIL rd_beat got=%h/%b/%b exp=%h/%b/%b", rdata_o, cur_idx, rlast_o, e.data, e.idx, e.last);
          end
        end
      end
      s_r_hs = bus_rvalid_i && bus_rready_o;
    end else if (rvalid_o !== 2'b00 || bus_rready_o !== 1'b0 || rlast_o !== 1'b0) begin
      failures++;
      $display("FAIL rd_idle got=%b/%b/%b exp=00/0/0 t=%0t", rvalid_o, bus_rready_o, rlast_o, $time);
    end
    checks++;
    if (phase == PH_W) begin
      if (bus_wvalid_o !== wvalid_i[cur_idx] || wready_o !== oh(cur_idx)) begin
        failures++;
        $display("FAIL wr_ctrl got=%b/%b exp=%b/%b", bus_wvalid_o, wready_o, wvalid_i[cur_idx], oh(cur_idx));
      end
      if (bus_wvalid_o && bus_wready_i) begin
        checks++;
        if (wr_q.size() == 0) begin
          failures++; $display("FAIL wr_extra_beat data=%h", bus_wdata_o);
        end else begin
          e = wr_q.pop_front();
          if (bus_wdata_o !== e.data || bus_wlast_o !== e.last) begin
            failures++;
            $display("FAIL wr_beat got=%h/%b exp=%h/%b", bus_wdata_o, bus_wlast_o, e.data, e.last);
          end
        end
        s_bw_last_hs = bus_wlast_o;
      end
    end else if (bus_wvalid_o !== 1'b0 || wready_o !== 2'b00) begin
      failures++; $display("FAIL wr_idle got=%b/%b exp=0/00 t=%0t", bus_wvalid_o, wready_o, $time);
    end
    for (int k = 0; k < 2; k++) s_w_hs[k] = wvalid_i[k] && wready_o[k];
    s_b = bus_bvalid_i;
  endtask

  task automatic run_until_idle(input int max_cyc, input string name);
    int n = 0;
    while (busy() && n < max_cyc) begin cyc_begin(); cyc_end(); n++; end
    checks++;
    if (busy()) begin
      failures++; $display("FAIL %s_timeout got=busy exp=idle after %0d cycles", name, n);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [12:0] v;
    v = {req_ready_o, wready_o, rvalid_o, rlast_o, wdone_o, bus_req_valid_o, bus_wvalid_o,
         bus_wlast_o, bus_rready_o};
    checks++;
    if (v !== 13'd0 || rdata_o !== '0) begin
      failures++; $display("FAIL %s got=%b/%h exp=0/0", name, v, rdata_o);
    end
  endtask

  task automatic test_reset();
    model_clear();
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_all_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin cyc_begin(); cyc_end(); end
  endtask

  task automatic test_dual_read();
    cyc_begin();
    issue(0, 32'h1000_0000, 1'b0, 3, '0);
    issue(1, 32'h2000_0100, 1'b0, 3, '0);
    cyc_end();
    run_until_idle(100, "dual_read");
  endtask

  task automatic test_write();
    wdone_cnt = 0;
    cyc_begin();
    issue(1, 32'h1C00_0040, 1'b1, 1, 32'hA5A5_0000);
    cyc_end();
    run_until_idle(60, "write");
    checks++;
    if (wdone_cnt != 1) begin failures++; $display("FAIL wdone_pulses got=%0d exp=1", wdone_cnt); end
  endtask

  task automatic test_addr_stall();
    stall_cnt = 0;
    aready_hold = 5;
    cyc_begin();
    issue(0, 32'h3000_0000, 1'b0, 0, '0);
    cyc_end();
    for (int c = 0; c < 80 && busy(); c++) begin
      cyc_begin();
      if (c == 2) issue(1, 32'h3000_1000, 1'b0, 1, '0);
      cyc_end();
    end
    checks++;
    if (stall_cnt != 5 || busy()) begin
      failures++; $display("FAIL addr_stall got=%0d/%0b exp=5/0", stall_cnt, busy());
    end
  endtask

  task automatic test_back_to_back();
    int   issued = 0;
    logic chk_next = 1'b0;
    logic just = 1'b0;
    for (int c = 0; c < 120 && (issued < 3 || busy()); c++) begin
      cyc_begin();
      just = 1'b0;
      if (phase == PH_NONE && req_valid_i == 2'b00 && issued < 3) begin
        issue(0, 32'h4000_0000 + 32'(issued * 16), 1'b0, 1, '0);
        issued++; just = 1'b1;
      end
      cyc_end();
      if (just) begin
        checks++;
        if (bus_req_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_idle_fwd got=1 exp=0"); end
      end
      if (chk_next) begin
        checks++;
        if (bus_req_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_latency got=0 exp=1"); end
      end
      chk_next = just;
    end
    checks++;
    if (issued != 3 || busy()) begin
      failures++; $display("FAIL b2b_done got=%0d/%0b exp=3/0", issued, busy());
    end
  endtask

  task automatic test_round_robin();
    cyc_begin();
    issue(1, 32'h7000_1000, 1'b1, 2, 32'hB000_0000);
    issue(0, 32'h7000_0000, 1'b0, 2, '0);
    cyc_end();
    run_until_idle(100, "round_robin");
  endtask

  task automatic test_rready_stall();
    rready_hold = 3;
    cyc_begin();
    issue(0, 32'h5000_0000, 1'b0, 2, '0);
    cyc_end();
    run_until_idle(60, "rready_stall");
    checks++;
    if (rready_hold != 0) begin failures++; $display("FAIL rready_stall_used got=%0d exp=0", rready_hold); end
  endtask

  task automatic test_reset_mid_read();
    cyc_begin();
    issue(0, 32'h6000_0000, 1'b0, 7, '0);
    cyc_end();
    for (int c = 0; c < 40 && rd_q.size() > 6; c++) begin cyc_begin(); cyc_end(); end
    checks++;
    if (rd_q.size() != 6) begin failures++; $display("FAIL mid_read_progress got=%0d exp=6", rd_q.size()); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_all_zero("reset_mid_read");
    model_clear();
    rst_n = 1'b1;
    cyc_begin(); cyc_end();
    cyc_begin();
    issue(0, 32'h6100_0000, 1'b0, 0, '0);
    issue(1, 32'h6200_0000, 1'b0, 0, '0);
    cyc_end();
    run_until_idle(60, "post_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_dual_read();
    test_write();
    test_addr_stall();
    test_back_to_back();
    test_round_robin();
    test_rready_stall();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_bus_arbiter.md
CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of write/read data beats.
REQ-002 Parameter LEN_WIDTH, default 4, burst length field (beats minus one).
REQ-003 Reset rst_n SHALL be synchronous, active-low; clock clk.
REQ-004 clk  input  1  clock; rst_n  input  1  synchronous active-low reset.
REQ-005 req_valid_i  input  [1:0]  per-requester transaction request (index 0 = icache, 1 = dcache).
REQ-006 req_ready_o  output  [1:0]  per-requester request accepted.
REQ-007 req_addr_i  input  [1:0][31:0]  request address; req_write_i  input  [1:0]  1 = write; req_len_i  input  [1:0][LEN_WIDTH-1:0]  beats-1.
REQ-008 wdata_i  input  [1:0][DATA_WIDTH-1:0]; wvalid_i  input  [1:0]; wlast_i  input  [1:0]; wready_o  output  [1:0]  write beat channel.
REQ-009 rdata_o  output  [DATA_WIDTH-1:0]; rvalid_o  output  [1:0]; rlast_o  output  1; rready_i  input  [1:0]  read beat channel.
REQ-010 wdone_o  output  [1:0]  one-cycle write completion pulse.
REQ-011 bus_req_valid_o/bus_req_ready_i, bus_addr_o[31:0], bus_write_o, bus_len_o[LEN_WIDTH-1:0]  downstream request channel.
REQ-012 bus_wdata_o, bus_wvalid_o, bus_wlast_o / bus_wready_i; bus_rdata_i, bus_rvalid_i, bus_rlast_i / bus_rready_o; bus_bvalid_i  downstream data/response channels.

Function
REQ-013 FSM states: IDLE, ADDR, WDATA, WRESP, RDATA.
REQ-014 IDLE: if any req_valid_i, register grant index, move to ADDR next cycle; no request forwarded in IDLE (1-cycle arbitration latency).
REQ-015 Arbitration SHALL be round-robin: both valid -> grant requester != last_grant; one valid -> grant it; last_grant updated on grant.
REQ-016 ADDR: bus_req_valid_o=1 with granted requester's addr/write/len; req_ready_o[grant]=bus_req_ready_i, other bit 0; on handshake -> WDATA if write else RDATA.
REQ-017 WDATA: bus_w* = granted wdata/wvalid/wlast; wready_o[grant]=bus_wready_i; on handshake with wlast -> WRESP.
REQ-018 WRESP: bus_bvalid_i -> wdone_o[grant]=1 for that cycle, -> IDLE.
REQ-019 RDATA: rdata_o=bus_rdata_i, rvalid_o[grant]=bus_rvalid_i, rlast_o=bus_rlast_i, bus_rready_o=rready_i[grant]; handshake with bus_rlast_i -> IDLE.
REQ-020 Non-granted requester SHALL see all of its ready/valid outputs 0 for the whole transaction; grant SHALL NOT change until return to IDLE.
REQ-021 Requester SHALL hold req_valid_i and payload stable until req_ready_o; deassertion before handshake is a protocol error (unsupported).
REQ-022 Requester request arriving in the cycle the FSM returns to IDLE SHALL be arbitrated in the following IDLE cycle (min 1 idle cycle between transactions).
REQ-023 Downstream valids SHALL be 0 in every state other than the owning channel state; bus_rready_o=0 outside RDATA.
REQ-024 Beat counting is not performed; completion is solely wlast/bus_rlast_i driven.

Reset
REQ-025 On rst_n=0: state=IDLE, last_grant=1 (requester 0 wins first contention), all *_valid_o, *_ready_o, wdone_o, rlast_o = 0.
REQ-026 Reset asserted mid-transaction SHALL abort to IDLE next cycle with no further handshakes; downstream recovery is the bus's responsibility.

Verification
REQ-027 Both requesters read (len=3) simultaneously after reset -> req0 granted, 4 beats to rvalid_o[0], then req1 granted, 4 beats to rvalid_o[1]; rvalid_o[1]=0 during req0 burst.
REQ-028 Req1 write len=1 addr 0x1C000040 -> bus_addr_o=0x1C000040, bus_write_o=1, 2 beats forwarded, wdone_o[1] pulses 1 cycle after bus_bvalid_i.
REQ-029 bus_req_ready_i held 0 for 5 cycles -> req_ready_o stays 0, addr stable, grant unchanged, then single handshake.
REQ-030 Back-to-back requests from req0 only with req1 idle -> req0 re-granted each time, one IDLE cycle between transactions.
REQ-031 rready_i[0]=0 with bus_rvalid_i=1 -> bus_rready_o=0, no beat lost; rst_n low during RDATA -> state IDLE, all outputs 0 next cycle.
